// File: rtl/uart_pkg.sv
// Shared UART definitions: framing FSM states, counter sizing and baud divider helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned DataBits = 8;
    localparam int unsigned CntWidth = 16;
    localparam int unsigned IdxWidth = $clog2(DataBits);

    function automatic logic [CntWidth-1:0] clks_per_bit(input int unsigned clock_rate,
                                                         input int unsigned baud_rate);
        int unsigned q;
        q = clock_rate / baud_rate;
        return q[CntWidth-1:0];
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: power-of-two depth, pointers carry one extra wrap bit.
// Read data is combinational from the head entry.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        // A push while full is dropped even if a pop frees a slot on the same edge.
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        rdata_o = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO; frames are sent back-to-back
// while bytes are queued, and o_DONE pulses as each stop bit ends.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_VALID,
    input  logic [7:0] i_DATA,
    output logic       o_READY,
    output logic       o_TX,
    output logic       o_BUSY,
    output logic       o_DONE
);

    localparam logic [CntWidth-1:0] ClksPerBit = clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam logic [CntWidth-1:0] BitLast    = ClksPerBit - CntWidth'(1);

    uart_state_e         state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic       fifo_pop;
    logic [7:0] fifo_rdata;
    logic       fifo_full;
    logic       fifo_empty;
    logic       bit_end;

    uart_tx_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (i_CLK),
        .rst_i  (i_RST),
        .push_i (i_VALID),
        .wdata_i(i_DATA),
        .pop_i  (fifo_pop),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign bit_end = (cnt_q == BitLast);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntWidth'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    tx_d     = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IdxWidth'(DataBits - 1)) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        idx_d   = idx_q + IdxWidth'(1);
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tx_d     = 1'b0;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign o_TX    = tx_q;
    assign o_DONE  = done_q;
    assign o_READY = !fifo_full;
    assign o_BUSY  = (state_q != StIdle) || !fifo_empty;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLOCK_RATE, 100000000, i_CLK frequency in Hz.
REQ-002 Parameter: BAUD_RATE, 9600, serial bit rate in baud.
REQ-003 Parameter: FIFO_DEPTH, 4, transmit buffer entries; power of two, at least 2.
REQ-004 Port: i_CLK  input  1  sole clock; all logic on rising edge.
REQ-005 Port: i_RST  input  1  reset, asynchronous, active-high.
REQ-006 Port: i_VALID  input  1  i_DATA holds a byte to queue.
REQ-007 Port: i_DATA  input  8  byte to transmit.
REQ-008 Port: o_READY  output  1  FIFO not full; byte accepted on an edge with i_VALID and o_READY both high.
REQ-009 Port: o_TX  output  1  serial line, idle high, registered.
REQ-010 Port: o_BUSY  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-011 Port: o_DONE  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-012 CLKS_PER_BIT SHALL equal CLOCK_RATE/BAUD_RATE (integer division); the bit counter SHALL be 16 bits wide.
REQ-013 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 Every bit, including the stop bit, SHALL hold on o_TX for exactly CLKS_PER_BIT cycles.
REQ-015 States SHALL be IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty; START->DATA after one bit period; DATA->STOP after the 8th bit period; STOP->START if FIFO non-empty, else STOP->IDLE.
REQ-016 FIFO pop SHALL occur on the edge leaving IDLE or STOP toward START; popped byte SHALL load the shift register on that edge and o_TX SHALL go low on that edge.
REQ-017 Latency: byte accepted into an empty FIFO while IDLE on edge N SHALL drive o_TX low from edge N+1; there is no write-to-line bypass.
REQ-018 Back-to-back frames SHALL be contiguous: 10*CLKS_PER_BIT cycles per frame, no idle cycles between them.
REQ-019 o_DONE SHALL pulse for exactly one cycle on the edge the stop bit ends, including when the next frame starts on that same edge.
REQ-020 o_READY SHALL be the combinational inverse of FIFO full; a push when full SHALL be ignored even if a pop occurs on the same edge.
REQ-021 Simultaneous push and pop on a non-full FIFO SHALL both take effect; occupancy is unchanged.
REQ-022 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by one extra pointer bit.
REQ-023 i_DATA SHALL be sampled only on an accepting edge; changes while o_READY is low SHALL have no effect.
REQ-024 o_BUSY SHALL be low only when state is IDLE and the FIFO is empty.

Reset
REQ-025 Asserting i_RST SHALL immediately force o_TX=1, o_BUSY=0, o_DONE=0, state IDLE, bit counter 0, bit index 0, and the FIFO empty, so o_READY=1.
REQ-026 Reset mid-frame SHALL abort the frame and discard all queued bytes, with no o_DONE pulse.
REQ-027 After i_RST deasserts, the first accepted byte SHALL transmit normally per REQ-017.

Structure
REQ-028 State encodings and a CLKS_PER_BIT computation function SHALL live in the shared package uart_pkg, which the receiver also uses.
REQ-029 The FIFO SHALL be a sub-module uart_tx_fifo (width 8, depth FIFO_DEPTH, async active-high reset); the framing FSM stays in uart_tx.

Verification (CLOCK_RATE=1000000, BAUD_RATE=100000, CLKS_PER_BIT=10)
REQ-030 Push 0x55 once -> o_TX low 10 cycles, then 1,0,1,0,1,0,1,0 for 10 cycles each, then high 10 cycles; o_DONE pulses 100 cycles after the start edge; o_BUSY falls on that edge.
REQ-031 Hold i_VALID for 6 cycles with 0x00,0xFF,0xA5,0x3C,0x81,0x7E -> first 5 accepted; o_READY low on the 6th; 5 contiguous frames totalling 500 cycles, with 5 o_DONE pulses.
REQ-032 Assert i_RST at cycle 35 of a frame, with 2 bytes queued -> o_TX=1 and o_BUSY=0 without waiting for a clock edge; no o_DONE; after release, a 0x81 push produces a correct single frame.
REQ-033 Change i_DATA every cycle while FIFO full -> only bytes from accepting edges appear on o_TX, in order.
REQ-034 Loopback o_TX into uart_rx with the same parameters, sending 0x00..0xFF back-to-back -> all 256 bytes received in order, with no framing errors.
